// File: rtl/cpu_branch_unit_if.sv
// rtl/cpu_branch_unit_if.sv - fetch/execute signal bundle for the branch resolution unit
interface cpu_branch_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  fetch_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic             ex_stall;
    logic [XLEN-1:0]  ex_pc;
    logic             ex_pred_taken;
    logic             jump;
    logic [1:0]       jump_src;
    logic             branch;
    logic [2:0]       branch_cond;
    logic             exception;
    logic             alu_carry;
    logic             alu_overflow;
    logic             alu_zero;
    logic             alu_neg;
    logic [2:0]       pc_src;
    logic             flush;
    logic             mispredict;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        output fetch_pc, ex_valid, ex_stall, ex_pc, ex_pred_taken, jump, jump_src,
               branch, branch_cond, exception, alu_carry, alu_overflow, alu_zero, alu_neg,
        input  pred_taken, pc_src, flush, mispredict, br_count, mispred_count
    );

    modport slave (
        input  fetch_pc, ex_valid, ex_stall, ex_pc, ex_pred_taken, jump, jump_src,
               branch, branch_cond, exception, alu_carry, alu_overflow, alu_zero, alu_neg,
        output pred_taken, pc_src, flush, mispredict, br_count, mispred_count
    );
endinterface

// File: rtl/cpu_branch_unit.sv
// rtl/cpu_branch_unit.sv - branch resolution, bimodal BHT predictor (CPU_BRANCH_PRED_EN) and perf counters
module cpu_branch_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input logic             clk,
    input logic             rst,
    cpu_branch_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [2:0] PC_SRC_PC_PLUS_4    = 3'd0;
    localparam logic [2:0] PC_SRC_PC_TARGET    = 3'd1;
    localparam logic [2:0] PC_SRC_ALU          = 3'd2;
    localparam logic [2:0] PC_SRC_MTVEC        = 3'd3;
    localparam logic [2:0] PC_SRC_MEPC         = 3'd4;
    localparam logic [2:0] PC_SRC_EX_PC_PLUS_4 = 3'd5;

    localparam logic [1:0] JUMP_SRC_PC_TARGET = 2'd0;
    localparam logic [1:0] JUMP_SRC_ALU       = 2'd1;
    localparam logic [1:0] JUMP_SRC_MTVEC     = 2'd2;

    localparam logic [2:0] BRANCH_COND_EQ  = 3'd0;
    localparam logic [2:0] BRANCH_COND_NE  = 3'd1;
    localparam logic [2:0] BRANCH_COND_LT  = 3'd4;
    localparam logic [2:0] BRANCH_COND_GE  = 3'd5;
    localparam logic [2:0] BRANCH_COND_LTU = 3'd6;
    localparam logic [2:0] BRANCH_COND_GEU = 3'd7;

`ifdef CPU_BRANCH_PRED_EN
    localparam logic PRED_EN = 1'b1;
`else
    localparam logic PRED_EN = 1'b0;
`endif

    logic             cond_true;
    logic             lt;
    logic             taken;
    logic             pred_eff;
    logic             resolved;
    logic             mispredict;
    logic [2:0]       pc_src;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;
    logic             unused_pc_bits;

    always_comb begin
        lt        = bus.alu_neg ^ bus.alu_overflow;
        cond_true = 1'b0;
        case (bus.branch_cond)
            BRANCH_COND_EQ:  cond_true = bus.alu_zero;
            BRANCH_COND_NE:  cond_true = !bus.alu_zero;
            BRANCH_COND_LT:  cond_true = lt;
            BRANCH_COND_GE:  cond_true = !lt;
            BRANCH_COND_LTU: cond_true = !bus.alu_carry;
            BRANCH_COND_GEU: cond_true = bus.alu_carry;
            default:         cond_true = 1'b0;
        endcase
    end

    // Without the predictor every branch was fetched as not-taken, whatever the pipe carries.
    assign pred_eff   = bus.ex_pred_taken & PRED_EN;
    assign taken      = bus.branch & cond_true;
    assign resolved   = bus.ex_valid & bus.branch & !bus.ex_stall & !bus.exception;
    assign mispredict = bus.ex_valid & bus.branch & !bus.exception & (taken != pred_eff);

    always_comb begin
        pc_src = PC_SRC_PC_PLUS_4;
        if (bus.ex_valid) begin
            if (bus.exception) begin
                pc_src = PC_SRC_MTVEC;
            end else if (bus.jump) begin
                case (bus.jump_src)
                    JUMP_SRC_PC_TARGET: pc_src = PC_SRC_PC_TARGET;
                    JUMP_SRC_ALU:       pc_src = PC_SRC_ALU;
                    JUMP_SRC_MTVEC:     pc_src = PC_SRC_MTVEC;
                    default:            pc_src = PC_SRC_MEPC;
                endcase
            end else if (bus.branch && taken && !pred_eff) begin
                pc_src = PC_SRC_PC_TARGET;
            end else if (bus.branch && !taken && pred_eff) begin
                pc_src = PC_SRC_EX_PC_PLUS_4;
            end
        end
    end

    assign bus.pc_src     = pc_src;
    assign bus.mispredict = mispredict;
    assign bus.flush      = bus.ex_valid & (bus.exception | bus.jump | mispredict);

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (resolved && br_count_q != '1) begin
            br_count_d = br_count_q + 1'b1;
        end
        if (resolved && mispredict && mispred_count_q != '1) begin
            mispred_count_d = mispred_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign bus.br_count      = br_count_q;
    assign bus.mispred_count = mispred_count_q;

`ifdef CPU_BRANCH_PRED_EN
    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d [BHT_ENTRIES];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;

    assign fetch_idx      = bus.fetch_pc[IDX_W+1:2];
    assign ex_idx         = bus.ex_pc[IDX_W+1:2];
    // Fetch reads the registered table, so a same-cycle update is not visible until next cycle.
    assign bus.pred_taken = bht_q[fetch_idx][1];

    always_comb begin
        bht_d = bht_q;
        if (resolved) begin
            if (taken && bht_q[ex_idx] != 2'b11) begin
                bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
            end else if (!taken && bht_q[ex_idx] != 2'b00) begin
                bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            bht_q <= bht_d;
        end
    end

    assign unused_pc_bits = ^{bus.fetch_pc[XLEN-1:IDX_W+2], bus.fetch_pc[1:0],
                              bus.ex_pc[XLEN-1:IDX_W+2], bus.ex_pc[1:0]};
`else
    assign bus.pred_taken = 1'b0;
    assign unused_pc_bits = ^{bus.fetch_pc, bus.ex_pc};
`endif
endmodule

// File: tb/tb_cpu_branch_unit.sv
// tb/tb_cpu_branch_unit.sv - directed self-checking bench for cpu_branch_unit
module tb_cpu_branch_unit;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

`ifdef CPU_BRANCH_PRED_EN
    localparam logic PE = 1'b1;
`else
    localparam logic PE = 1'b0;
`endif

    localparam logic [2:0] PC4 = 3'd0, TGT = 3'd1, ALU = 3'd2, MTVEC = 3'd3, MEPC = 3'd4, EXPC4 = 3'd5;
    localparam logic [2:0] C_EQ = 3'd0, C_NE = 3'd1, C_LT = 3'd4, C_GE = 3'd5, C_LTU = 3'd6, C_GEU = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpu_branch_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    cpu_branch_unit #(.XLEN(XLEN), .BHT_ENTRIES(64), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.ex_valid = 0; bus.ex_stall = 0; bus.ex_pc = '0; bus.ex_pred_taken = 0;
        bus.jump = 0; bus.jump_src = 0; bus.branch = 0; bus.branch_cond = 0; bus.exception = 0;
        bus.alu_carry = 0; bus.alu_overflow = 0; bus.alu_zero = 0; bus.alu_neg = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beq(input logic [31:0] pc, input logic zero, input logic pred);
        idle();
        bus.ex_valid = 1; bus.branch = 1; bus.branch_cond = C_EQ;
        bus.ex_pc = pc; bus.alu_zero = zero; bus.ex_pred_taken = pred;
        #1;
    endtask

    task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
        bus.fetch_pc = pc;
        #1;
        check(tag, bus.pred_taken, exp);
    endtask

    task automatic cond_case(input string tag, input logic [2:0] c, input logic z, input logic n,
                             input logic v, input logic cy, input logic exp);
        idle();
        bus.ex_valid = 1; bus.ex_stall = 1; bus.branch = 1; bus.branch_cond = c;
        bus.alu_zero = z; bus.alu_neg = n; bus.alu_overflow = v; bus.alu_carry = cy;
        #1;
        check(tag, bus.mispredict, exp);
    endtask

    initial begin
        idle();
        bus.fetch_pc = 32'h100;
        rst = 1;
        tick(); tick();
        check("rst_pc_src", bus.pc_src, PC4);
        rst = 0;
        tick();
        pred_at("rst_pred", 32'h100, 1'b0);
        check("rst_br_count", bus.br_count, 0);
        check("rst_mis_count", bus.mispred_count, 0);

        beq(32'h100, 1, 0);
        check("beq_pc_src", bus.pc_src, TGT);
        check("beq_flush", bus.flush, 1);
        check("beq_mispredict", bus.mispredict, 1);
        tick();
        idle();
        pred_at("beq_pred_after", 32'h100, PE);
        check("beq_br_count", bus.br_count, 1);
        check("beq_mis_count", bus.mispred_count, 1);

        for (int i = 0; i < 4; i++) begin
            beq(32'h100, 1, 1);
            if (i == 0) begin
                check("taken4_pc_src", bus.pc_src, PE ? PC4 : TGT);
                check("taken4_flush", bus.flush, !PE);
            end
            tick();
        end
        idle();
        check("taken4_br_count", bus.br_count, 5);
        check("taken4_mis_count", bus.mispred_count, PE ? 1 : 5);
        pred_at("alias_pred_0x200", 32'h200, PE);
        pred_at("other_idx_pred_0x104", 32'h104, 1'b0);

        beq(32'h100, 0, 1);
        check("nt_pc_src", bus.pc_src, PE ? EXPC4 : PC4);
        check("nt_mispredict", bus.mispredict, PE);
        check("nt_flush", bus.flush, PE);
        tick();
        idle();
        pred_at("nt_pred_weak_t", 32'h100, PE);
        beq(32'h100, 0, 1);
        tick();
        idle();
        pred_at("nt2_pred_weak_nt", 32'h100, 1'b0);
        check("nt2_br_count", bus.br_count, 7);
        check("nt2_mis_count", bus.mispred_count, PE ? 3 : 5);

        beq(32'h100, 1, 0);
        bus.jump = 1; bus.exception = 1;
        #1;
        check("exc_pc_src", bus.pc_src, MTVEC);
        check("exc_flush", bus.flush, 1);
        check("exc_mispredict", bus.mispredict, 0);
        tick();
        idle();
        pred_at("exc_pred_unchanged", 32'h100, 1'b0);
        check("exc_br_count", bus.br_count, 7);

        idle();
        bus.ex_valid = 1; bus.jump = 1; bus.jump_src = 2'd3;
        #1;
        check("jump_mepc_pc_src", bus.pc_src, MEPC);
        check("jump_flush", bus.flush, 1);
        bus.jump_src = 2'd1;
        #1;
        check("jump_alu_pc_src", bus.pc_src, ALU);
        tick();
        check("jump_br_count", bus.br_count, 7);

        beq(32'h100, 1, 0);
        bus.ex_stall = 1;
        #1;
        check("stall_pc_src", bus.pc_src, TGT);
        check("stall_mispredict", bus.mispredict, 1);
        tick();
        idle();
        pred_at("stall_pred_unchanged", 32'h100, 1'b0);
        check("stall_br_count", bus.br_count, 7);
        check("stall_mis_count", bus.mispred_count, PE ? 3 : 5);

        beq(32'h100, 1, 0);
        bus.ex_valid = 0;
        #1;
        check("invalid_pc_src", bus.pc_src, PC4);
        check("invalid_flush", bus.flush, 0);
        check("invalid_mispredict", bus.mispredict, 0);

        cond_case("cond_ne",        C_NE,  0, 0, 0, 0, 1);
        cond_case("cond_ne_zero",   C_NE,  1, 0, 0, 0, 0);
        cond_case("cond_lt",        C_LT,  0, 1, 0, 0, 1);
        cond_case("cond_lt_ovf",    C_LT,  0, 1, 1, 0, 0);
        cond_case("cond_ge",        C_GE,  0, 0, 0, 0, 1);
        cond_case("cond_ltu",       C_LTU, 0, 0, 0, 0, 1);
        cond_case("cond_geu",       C_GEU, 0, 0, 0, 0, 0);
        cond_case("cond_geu_carry", C_GEU, 0, 0, 0, 1, 1);
        cond_case("cond_rsvd2",     3'd2,  1, 1, 0, 1, 0);
        cond_case("cond_rsvd3",     3'd3,  1, 1, 0, 1, 0);

        for (int i = 0; i < 12; i++) begin
            beq(32'h300, 1, 0);
            tick();
        end
        idle();
        check("sat_br_count", bus.br_count, 15);
        check("sat_mis_count", bus.mispred_count, 15);
        pred_at("sat_pred_0x100", 32'h100, PE);
        beq(32'h300, 1, 0);
        tick();
        idle();
        check("sat_br_hold", bus.br_count, 15);
        check("sat_mis_hold", bus.mispred_count, 15);

        rst = 1;
        tick();
        rst = 0;
        tick();
        pred_at("rerst_pred", 32'h100, 1'b0);
        check("rerst_br_count", bus.br_count, 0);
        check("rerst_mis_count", bus.mispred_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_branch_unit.md
# cpu_branch_unit

Parametrised branch resolution unit with a dynamic direction predictor. It replaces the purely combinational PC-source selection in the execute stage with three parts: a bimodal branch history table (BHT) read at fetch, resolution logic at execute, and mispredict/flush generation. It also keeps saturating branch and mispredict performance counters.

## Interface
- `XLEN`, 32, datapath/PC width
- `BHT_ENTRIES`, 64, number of 2-bit counters; power of two, ≥2
- `CNT_W`, 32, performance counter width
- `clk` input 1, clock
- `rst` input 1, reset; synchronous, active-high
- `fetch_pc` input XLEN, PC being fetched
- `pred_taken` output 1, predicted direction for `fetch_pc`
- `ex_valid` input 1, execute stage holds a real instruction
- `ex_stall` input 1, execute stage stalled this cycle
- `ex_pc` input XLEN, PC of execute instruction
- `ex_pred_taken` input 1, `pred_taken` carried down the pipe with the instruction
- `jump` input 1, unconditional control transfer
- `jump_src` input 2, `JUMP_SRC_*` encoding
- `branch` input 1, conditional branch
- `branch_cond` input 3, `BRANCH_COND_*` encoding
- `exception` input 1, trap in execute
- `alu_carry`, `alu_overflow`, `alu_zero`, `alu_neg` inputs 1 each, compare flags
- `pc_src` output 3, next-PC select (`PC_SRC_*`)
- `flush` output 1, kill younger instructions in fetch/decode
- `mispredict` output 1, conditional branch direction was wrong
- `br_count` output CNT_W, resolved conditional branches
- `mispred_count` output CNT_W, mispredicted conditional branches

## Operation
- Index: `idx = pc[$clog2(BHT_ENTRIES)+1:2]`.
- BHT counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. `pred_taken = bht[idx(fetch_pc)][1]`.
- Condition evaluation:
  - `lt = alu_neg ^ alu_overflow`.
  - EQ = zero; NE = !zero; LT = lt; GE = !lt; LTU = !carry; GEU = carry.
  - Any other encoding evaluates as not-taken.
- `taken = branch & cond`. The branch is "resolved" when `ex_valid & branch & !ex_stall & !exception`.
- `pc_src` priority:
  1. `exception` → `PC_SRC_MTVEC`.
  2. `jump` → mapped from `jump_src` (PC_TARGET, ALU, MTVEC, MEPC).
  3. `branch & taken & !ex_pred_taken` → `PC_SRC_PC_TARGET`.
  4. `branch & !taken & ex_pred_taken` → `PC_SRC_EX_PC_PLUS_4`. This is a new encoding, 3'd5, added to cpu_control.vh; the next PC is `ex_pc + 4`.
  5. Otherwise → `PC_SRC_PC_PLUS_4`.
- When `!ex_valid`, `pc_src = PC_SRC_PC_PLUS_4` and `flush = mispredict = 0`.
- `mispredict = ex_valid & branch & !exception & (taken != ex_pred_taken)`.
- `flush = ex_valid & (exception | jump | mispredict)`.
- On a resolved branch, counter `bht[idx(ex_pc)]` increments if taken and decrements if not, saturating at 11 and 00.
- Jumps, exceptions and stalled cycles never update the BHT.
- `br_count` increments on every resolved branch. `mispred_count` increments on every resolved branch that mispredicts. Both saturate at all-ones.

## Timing
- `pred_taken` is combinational from `fetch_pc` and current BHT contents.
- `pc_src`, `flush` and `mispredict` are combinational from execute inputs.
- BHT and counter updates take effect at the `clk` edge after resolution.
- Same-cycle read/update of one index: fetch sees the old value; no bypass.
- Reset: all BHT entries go to 01 in the reset cycle, so `pred_taken = 0` from the first cycle after reset. `br_count = mispred_count = 0`.
- Reset mid-operation: any update pending in that cycle is discarded.
- The combinational outputs follow their inputs during reset. The pipeline must hold `ex_valid = 0` while `rst` is high.

## Configuration
- `CPU_BRANCH_PRED_EN` defined: BHT instantiated, behaviour as above.
- Not defined: no BHT storage and `pred_taken` is tied to 0 (static not-taken). Rule 4 is therefore unreachable, and every taken branch counts as a mispredict with `flush = 1`. Performance counters remain.

## Test plan
- Reset, then `fetch_pc = 0x100` → `pred_taken = 0`; both counters read 0.
- BEQ at `ex_pc = 0x100`, `alu_zero = 1`, `ex_pred_taken = 0`:
  - → `pc_src = PC_SRC_PC_TARGET`, `flush = mispredict = 1`.
  - Next cycle `pred_taken(0x100) = 1`; `br_count = 1`, `mispred_count = 1`.
- Four consecutive taken resolutions at 0x100, then one not-taken with `ex_pred_taken = 1` → `pc_src = PC_SRC_EX_PC_PLUS_4`, `mispredict = 1`; the counter reads 10 afterwards.
- `exception = 1` together with `branch = 1` and `jump = 1` → `pc_src = PC_SRC_MTVEC`, `flush = 1`, `mispredict = 0`, no BHT or counter change.
- Resolved branch with `ex_stall = 1` → `pc_src` reflects the outcome, but BHT and counters are unchanged.
- Aliasing: with `BHT_ENTRIES = 64`, training 0x100 taken also gives `pred_taken = 1` for 0x200; preload `mispred_count` near all-ones and confirm it saturates.
